// File: rtl/oled_time_streamer_if.sv
// Byte handshake between the time streamer and the SPI byte master.
// Latency: wires only, no registers.
// Backpressure: the source holds each byte until it sees spi_send_done for it.
interface oled_time_streamer_if;
  logic       spi_send;
  logic [7:0] spi_data;
  logic       dc;
  logic       spi_send_done;

  modport master (output spi_send, output spi_data, output dc, input spi_send_done);
  modport slave  (input spi_send, input spi_data, input dc, output spi_send_done);
endinterface

// File: rtl/oled_time_streamer.sv
// Streams "HH:MM:SS" (8x16 font) to the OLED as two page command triplets plus 128 glyph bytes.
// Latency: first spi_send two cycles after an accepted refresh; each next send two cycles after done.
// Backpressure: one byte in flight; the next byte is only loaded after spi_send_done for the current one.
module oled_time_streamer #(
  parameter int START_PAGE = 3,
  parameter int START_COL  = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        refresh,
  input  logic [23:0]                 time_bcd,
  input  logic                        colon_on,
  oled_time_streamer_if.master        spi,
  output logic                        busy,
  output logic                        frame_done
);

  localparam logic [7:0] PAGE_BASE = 8'(START_PAGE);
  localparam logic [7:0] COL_VAL   = 8'(START_COL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [23:0] snap_time;
  logic        snap_colon;
  logic        pending;
  logic        page_bit;
  logic [2:0]  chr_idx;
  logic [2:0]  col_idx;
  logic [1:0]  cmd_idx;   // 0..2 = command bytes, 3 = data phase of the page

  logic [3:0]  char_code;
  logic [63:0] glyph;
  logic [2:0]  sh;
  logic [7:0]  data_byte;
  logic [7:0]  cmd_byte;
  logic [7:0]  next_byte;
  logic        next_dc;
  logic        last_byte;

  // Seven-segment style digit font. One half (8 column bytes) per call,
  // written left column first; LSB of each byte is the top pixel row of the half.
  function automatic logic [63:0] glyph_half(input logic [3:0] code, input logic half);
    logic [63:0] w;
    w = 64'h0;
    case ({code, half})
      5'b0000_0: w = 64'h00FEFE0606FEFE00;
      5'b0000_1: w = 64'h007F7F60607F7F00;
      5'b0001_0: w = 64'h0000000000FEFE00;
      5'b0001_1: w = 64'h00000000007F7F00;
      5'b0010_0: w = 64'h0086868686FEFE00;
      5'b0010_1: w = 64'h007F7F6161616100;
      5'b0011_0: w = 64'h0086868686FEFE00;
      5'b0011_1: w = 64'h00616161617F7F00;
      5'b0100_0: w = 64'h00FEFE8080FEFE00;
      5'b0100_1: w = 64'h00010101017F7F00;
      5'b0101_0: w = 64'h00FEFE8686868600;
      5'b0101_1: w = 64'h00616161617F7F00;
      5'b0110_0: w = 64'h00FEFE8686868600;
      5'b0110_1: w = 64'h007F7F61617F7F00;
      5'b0111_0: w = 64'h0006060606FEFE00;
      5'b0111_1: w = 64'h00000000007F7F00;
      5'b1000_0: w = 64'h00FEFE8686FEFE00;
      5'b1000_1: w = 64'h007F7F61617F7F00;
      5'b1001_0: w = 64'h00FEFE8686FEFE00;
      5'b1001_1: w = 64'h00616161617F7F00;
      5'b1010_0: w = 64'h0000003030000000;  // colon, upper dot
      5'b1010_1: w = 64'h0000000C0C000000;  // colon, lower dot
      default:   w = 64'h0;                 // 0xB..0xF render blank
    endcase
    return w;
  endfunction

  // Select the byte for the current counters from the snapshot and font.
  always_comb begin
    char_code = 4'hB;
    glyph     = 64'h0;
    sh        = 3'd0;
    data_byte = 8'h00;
    cmd_byte  = 8'h00;
    next_byte = 8'h00;
    next_dc   = 1'b0;
    last_byte = 1'b0;

    case (chr_idx)
      3'd0: char_code = snap_time[23:20];
      3'd1: char_code = snap_time[19:16];
      3'd3: char_code = snap_time[15:12];
      3'd4: char_code = snap_time[11:8];
      3'd6: char_code = snap_time[7:4];
      3'd7: char_code = snap_time[3:0];
      default: char_code = snap_colon ? 4'hA : 4'hB;
    endcase

    glyph     = glyph_half(char_code, page_bit);
    sh        = 3'd7 - col_idx;
    data_byte = glyph[{sh, 3'b000} +: 8];

    case (cmd_idx)
      2'd0:    cmd_byte = 8'hB0 | (PAGE_BASE + {7'd0, page_bit});
      2'd1:    cmd_byte = {4'h0, COL_VAL[3:0]};
      2'd2:    cmd_byte = {4'h1, COL_VAL[7:4]};
      default: cmd_byte = 8'h00;
    endcase

    next_dc   = (cmd_idx == 2'd3);
    next_byte = next_dc ? data_byte : cmd_byte;
    last_byte = page_bit && (cmd_idx == 2'd3) && (chr_idx == 3'd7) && (col_idx == 3'd7);
  end

  // Frame sequencer: snapshot on start, one byte per LOAD/SEND/WAIT round, pending refresh replay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      snap_time    <= 24'h0;
      snap_colon   <= 1'b0;
      pending      <= 1'b0;
      page_bit     <= 1'b0;
      chr_idx      <= 3'd0;
      col_idx      <= 3'd0;
      cmd_idx      <= 2'd0;
      spi.spi_send <= 1'b0;
      spi.spi_data <= 8'h00;
      spi.dc       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      spi.spi_send <= 1'b0;
      frame_done   <= 1'b0;

      // Requests during a frame collapse into one; losing enable drops them.
      if (!enable) begin
        pending <= 1'b0;
      end else if (refresh && state != S_IDLE) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (enable && refresh) begin
            snap_time  <= time_bcd;
            snap_colon <= colon_on;
            page_bit   <= 1'b0;
            chr_idx    <= 3'd0;
            col_idx    <= 3'd0;
            cmd_idx    <= 2'd0;
            pending    <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          spi.spi_data <= next_byte;
          spi.dc       <= next_dc;
          spi.spi_send <= 1'b1;
          state        <= S_SEND;
        end

        S_SEND: begin
          // A done coincident with the send pulse is not for this byte.
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (spi.spi_send_done) begin
            if (last_byte) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_LOAD;
              if (cmd_idx != 2'd3) begin
                cmd_idx <= cmd_idx + 2'd1;
              end else if (col_idx != 3'd7) begin
                col_idx <= col_idx + 3'd1;
              end else begin
                col_idx <= 3'd0;
                if (chr_idx != 3'd7) begin
                  chr_idx <= chr_idx + 3'd1;
                end else begin
                  chr_idx  <= 3'd0;
                  cmd_idx  <= 2'd0;
                  page_bit <= 1'b1;
                end
              end
            end
          end
        end

        S_DONE: begin
          if (enable && (pending || refresh)) begin
            snap_time  <= time_bcd;
            snap_colon <= colon_on;
            page_bit   <= 1'b0;
            chr_idx    <= 3'd0;
            col_idx    <= 3'd0;
            cmd_idx    <= 2'd0;
            pending    <= 1'b0;
            state      <= S_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/oled_time_streamer.md
# oled_time_streamer

Upstream byte source for the OLED SPI path: renders a six-digit BCD time as "HH:MM:SS" in an 8×16 font and streams the page/column commands plus glyph bytes to the SPI byte master over the send/done handshake. It sits beside the draw stage and is selected once OLED init has completed. Each frame is snapshotted at start, so the panel never shows a torn time.

## Interface
- START_PAGE, 3, first of two OLED pages written (0–6)
- START_COL, 32, first column of the 64-column text field (0–64)
- clk  in  1  byte-handshake clock, same clock as the SPI master's handshake side
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high once OLED init is done; refresh ignored while low
- refresh  in  1  one-cycle request to redraw
- time_bcd  in  24  {h1,h0,m1,m0,s1,s0}, 4-bit codes each
- colon_on  in  1  1 = draw colons, 0 = blank glyph in colon positions (blink)
- spi_send_done  in  1  one-cycle pulse from SPI master, byte shifted out
- spi_send  out  1  one-cycle pulse, byte valid
- spi_data  out  8  byte to send
- dc  out  1  0 = command, 1 = data
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last byte's done

## Operation
- Glyph codes: 0–9 digits, 0xA colon, 0xB–0xF blank (all bytes 0x00). Glyph ROM is 12×16 bytes from the team 8×16 digit font. Bytes 0–7 form the top half, column order left→right, LSB = top pixel. Bytes 8–15 form the bottom half.
- Character string: h1,h0,C,m1,m0,C,s1,s0. C = 0xA if colon_on else 0xB.
- refresh is accepted when enable=1 and the block is IDLE.
- On acceptance, snapshot time_bcd and colon_on into internal registers. Later input changes have no effect on the current frame.
- Per page p in {START_PAGE, START_PAGE+1}, send in order:
  - Three commands with dc=0: 0xB0|p, 0x00|START_COL[3:0], 0x10|START_COL[7:4].
  - 64 data bytes with dc=1: for char k=0..7 and col c=0..7, glyph(k) byte (c + 8·half), where half=0 on the first page and 1 on the second.
- A frame is 134 sends.
- FSM states: IDLE → LOAD (snapshot, select byte) → SEND (spi_send=1, one cycle) → WAIT (hold until spi_send_done) → next LOAD or DONE → IDLE.
- Pending refresh: refresh while busy sets a pending flag (multiple requests collapse to one). After DONE, if pending and enable=1, the next frame starts with a fresh snapshot. Pending is cleared at that start.
- enable falling mid-frame: the current frame completes; pending is dropped.
- spi_send_done outside WAIT, or in the same cycle as spi_send, is ignored.
- Async reset (including mid-frame): spi_send=0, spi_data=0x00, dc=0, busy=0, frame_done=0, pending=0, state=IDLE. No partial byte is reissued after reset.

## Timing
- refresh sampled high at edge N (IDLE, enable=1) → busy=1 and LOAD from N+1 → first spi_send pulse at N+2.
- spi_data and dc are valid in the spi_send cycle and held stable until the matching spi_send_done.
- spi_send_done at edge M → next spi_send at M+2 (via LOAD).
- After the final (134th) spi_send_done at edge M:
  - frame_done=1 for the cycle after M.
  - busy=0 at M+2.
  - If pending, busy stays 1 and the next spi_send occurs at M+3.
- Internal counters: page bit (1), char index (3), column (3), command index (2). Counters wrap only by state transition, never arithmetically.
- Max frame time with a responder asserting done D cycles after send: 134·(D+2)+3 cycles.

## Test plan
- Reset, time_bcd=0xBBBBBB, colon_on=0, enable=1, refresh, SPI responder with done 3 cycles after send → 134 sends. Sends 1–3 are 0xB3, 0x00, 0x12 with dc=0. Sends 4–67 are 0x00 with dc=1. Sends 68–70 are 0xB4, 0x00, 0x12. frame_done once; busy low 2 cycles after the last done.
- time_bcd=0x123456, colon_on=1 → data bytes match the golden font model. Char 2 equals glyph 0xA. Change time_bcd to 0x000000 mid-frame → no change in output bytes.
- enable=0, refresh → no spi_send, busy stays 0.
- Three refresh pulses during a frame → exactly one additional frame follows, with first send 3 cycles after the first frame's last done.
- Assert reset_n low during WAIT of send 50 → all outputs 0 immediately. After release with no refresh → no sends.
- Spurious spi_send_done in IDLE and coincident with spi_send → ignored. Byte count stays 134 and data is held until a valid done.
